mul19_compressor: RTL and testbench
===================================

Name: mul19_compressor

Overview:
- Bit-heap compressor for a 19x19 unsigned multiplier.
- Takes the partial-product matrix as 37 weighted columns. Column i has weight 2^i; column heights are 1,2,...,19,...,2,1.
- Reduces the columns to a single binary result using a carry-save (Wallace/Dadda) tree and a final carry-propagate adder.
- Sits between the partial-product generator and the product output register stage.

Parameters:
- None. Geometry is fixed at 19x19: 37 input columns, 39 result bits.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- src0 .. src36  input  h_i  column i bits, all of weight 2^i, where h_i = min(i+1, 37-i). So src0=1, src1=2, ... src18=19, src19=18, ... src36=1 bit.
- dst0 .. dst38  output  1 each  result bit j, weight 2^j (dst0 is the LSB)

Behaviour:
- Function: R = sum over i=0..36 of popcount(src_i) * 2^i. Output {dst38..dst0} = R.
  - Bits within a column are interchangeable; only their count matters.
- Range:
  - Maximum R is reached with every input bit set: R = (2^19-1)^2 = 0x3F_FFF0_0001, which is below 2^38.
  - dst38 is therefore always 0. It exists for interface regularity and must be driven, not left floating.
- Latency: exactly 1 clock cycle. Inputs sampled on rising clk edge N appear on dst at edge N, i.e. after the clock-to-Q delay following that edge.
  - One output register stage holds all 39 dst bits.
  - Reduction logic is combinational between the inputs and that register.
  - No input register; no handshake; a new input set is accepted every cycle.
- Reset:
  - rst_n low clears all dst bits to 0 asynchronously, independent of clk.
  - While rst_n is low, dst stays 0.
  - First valid output is at the first rising edge after rst_n deasserts, reflecting the inputs present at that edge.
- Reset mid-operation: the in-flight result is discarded and dst goes to 0 immediately. No recovery or replay.
- Arithmetic:
  - All values are unsigned.
  - Full adders (3:2) and half adders (2:2) are built from XOR/AND/OR.
  - The final two-row addition is a 39-bit ripple or prefix adder.
  - No truncation: every carry must propagate up to bit 38.
- Inputs with X/Z are outside specification.
- Implementation note: an explicit tree of adder instances, generated or written out, is expected in about 120-400 lines. A behavioural popcount-and-sum is acceptable only if it is bit-exact with the function above.

Test Plan:
- All src zero, rst_n high -> after 1 clk all dst = 0.
- All src bits set (equivalent to multiplying 0x7FFFF by 0x7FFFF) -> dst[38:0] = 0x3F_FFF0_0001 after 1 clk; dst38 = 0.
- Single bit: only src36[0]=1 -> dst36=1, all others 0. Only src0[0]=1 -> dst0=1, all others 0.
- Column 18 fully set (19 ones), all else 0 -> R = 19*2^18 = 0x4C_0000, so dst18, dst19 and dst22 = 1 and all others 0. This checks carries crossing multiple columns.
- Random regression against a golden model:
  - Drive random a, b (19-bit) and build the column matrix src_i from a[k]&b[i-k].
  - Expect R = a*b one cycle later, for 10k+ vectors with back-to-back inputs every cycle.
  - Also drive fully random column bits and compare against the popcount-sum model.
- Reset checks:
  - Drive the all-ones input and pull rst_n low between clock edges -> dst goes to 0 immediately, without waiting for clk.
  - Release rst_n -> dst equals the correct value for the inputs present at the next rising edge.

Source files
------------

// File: rtl/mul19_compressor.sv
// mul19_compressor
//   Bit-heap reduction for a 19x19 unsigned multiplier. Column i of the
//   partial-product matrix (weight 2^i) arrives on src<i>, holding
//   min(i+1, 37-i) interchangeable bits. A Wallace tree of full/half adders
//   reduces the heap to two rows, which a 39-bit ripple adder sums. The
//   result is registered once and presented on dst0..dst38.
//
// Ports
//   clk            rising-edge clock
//   rst_n          asynchronous active-low reset, clears all dst bits
//   src0..src36    column bits, width min(i+1, 37-i)
//   dst0..dst38    registered result bits, dst0 = LSB (dst38 is always 0)
module mul19_compressor (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [0:0]  src0,
    input  logic [1:0]  src1,
    input  logic [2:0]  src2,
    input  logic [3:0]  src3,
    input  logic [4:0]  src4,
    input  logic [5:0]  src5,
    input  logic [6:0]  src6,
    input  logic [7:0]  src7,
    input  logic [8:0]  src8,
    input  logic [9:0]  src9,
    input  logic [10:0] src10,
    input  logic [11:0] src11,
    input  logic [12:0] src12,
    input  logic [13:0] src13,
    input  logic [14:0] src14,
    input  logic [15:0] src15,
    input  logic [16:0] src16,
    input  logic [17:0] src17,
    input  logic [18:0] src18,
    input  logic [17:0] src19,
    input  logic [16:0] src20,
    input  logic [15:0] src21,
    input  logic [14:0] src22,
    input  logic [13:0] src23,
    input  logic [12:0] src24,
    input  logic [11:0] src25,
    input  logic [10:0] src26,
    input  logic [9:0]  src27,
    input  logic [8:0]  src28,
    input  logic [7:0]  src29,
    input  logic [6:0]  src30,
    input  logic [5:0]  src31,
    input  logic [4:0]  src32,
    input  logic [3:0]  src33,
    input  logic [2:0]  src34,
    input  logic [1:0]  src35,
    input  logic [0:0]  src36,
    output logic        dst0,  output logic dst1,  output logic dst2,
    output logic        dst3,  output logic dst4,  output logic dst5,
    output logic        dst6,  output logic dst7,  output logic dst8,
    output logic        dst9,  output logic dst10, output logic dst11,
    output logic        dst12, output logic dst13, output logic dst14,
    output logic        dst15, output logic dst16, output logic dst17,
    output logic        dst18, output logic dst19, output logic dst20,
    output logic        dst21, output logic dst22, output logic dst23,
    output logic        dst24, output logic dst25, output logic dst26,
    output logic        dst27, output logic dst28, output logic dst29,
    output logic        dst30, output logic dst31, output logic dst32,
    output logic        dst33, output logic dst34, output logic dst35,
    output logic        dst36, output logic dst37, output logic dst38
);

    // 19 -> 13 -> 9 -> 6 -> 4 -> 3 -> 2 needs six layers; two spare layers
    // collapse to pass-through once every column is already two bits or less.
    localparam int NUM_STAGES = 8;

    function automatic int col_height(input int c);
        if (c < 19)
            return c + 1;
        else if (c < 37)
            return 37 - c;
        else
            return 0;
    endfunction

    // returns {carry, sum}
    function automatic logic [1:0] fa(input logic x, input logic y, input logic z);
        return {(x & y) | (z & (x ^ y)), x ^ y ^ z};
    endfunction

    function automatic logic [1:0] ha(input logic x, input logic y);
        return {x & y, x ^ y};
    endfunction

    logic [36:0][18:0] col_in;

    assign col_in[0]  = 19'(src0);
    assign col_in[1]  = 19'(src1);
    assign col_in[2]  = 19'(src2);
    assign col_in[3]  = 19'(src3);
    assign col_in[4]  = 19'(src4);
    assign col_in[5]  = 19'(src5);
    assign col_in[6]  = 19'(src6);
    assign col_in[7]  = 19'(src7);
    assign col_in[8]  = 19'(src8);
    assign col_in[9]  = 19'(src9);
    assign col_in[10] = 19'(src10);
    assign col_in[11] = 19'(src11);
    assign col_in[12] = 19'(src12);
    assign col_in[13] = 19'(src13);
    assign col_in[14] = 19'(src14);
    assign col_in[15] = 19'(src15);
    assign col_in[16] = 19'(src16);
    assign col_in[17] = 19'(src17);
    assign col_in[18] = 19'(src18);
    assign col_in[19] = 19'(src19);
    assign col_in[20] = 19'(src20);
    assign col_in[21] = 19'(src21);
    assign col_in[22] = 19'(src22);
    assign col_in[23] = 19'(src23);
    assign col_in[24] = 19'(src24);
    assign col_in[25] = 19'(src25);
    assign col_in[26] = 19'(src26);
    assign col_in[27] = 19'(src27);
    assign col_in[28] = 19'(src28);
    assign col_in[29] = 19'(src29);
    assign col_in[30] = 19'(src30);
    assign col_in[31] = 19'(src31);
    assign col_in[32] = 19'(src32);
    assign col_in[33] = 19'(src33);
    assign col_in[34] = 19'(src34);
    assign col_in[35] = 19'(src35);
    assign col_in[36] = 19'(src36);

    // Heap state per layer. Heights are elaboration constants (they depend
    // only on column geometry), so the loops unroll into a fixed adder tree.
    logic [38:0][18:0] cur;
    logic [38:0][18:0] nxt;
    int                h_cur [39];
    int                h_nxt [39];
    int                max_h;
    int                n;
    int                r;
    logic [1:0]        cs;
    logic              carry;
    logic [38:0]       sum_c;

    always_comb begin
        cur   = '0;
        nxt   = '0;
        max_h = 0;
        n     = 0;
        r     = 0;
        cs    = '0;
        carry = 1'b0;
        sum_c = '0;
        for (int c = 0; c < 39; c++) begin
            h_cur[c] = col_height(c);
            h_nxt[c] = 0;
        end
        for (int c = 0; c < 37; c++)
            cur[c] = col_in[c];

        for (int s = 0; s < NUM_STAGES; s++) begin
            max_h = 0;
            for (int c = 0; c < 39; c++) begin
                if (h_cur[c] > max_h)
                    max_h = h_cur[c];
                h_nxt[c] = 0;
            end
            nxt = '0;

            for (int c = 0; c < 39; c++) begin
                n = h_cur[c];
                r = 0;
                if (max_h <= 2) begin
                    nxt[6'(c)][1:0] = cur[6'(c)][1:0];
                    h_nxt[c]        = n;
                end else begin
                    for (int g = 0; g < 7; g++) begin
                        if (r + 3 <= n) begin
                            cs = fa(cur[6'(c)][5'(r)], cur[6'(c)][5'(r + 1)],
                                    cur[6'(c)][5'(r + 2)]);
                            nxt[6'(c)][5'(h_nxt[c])] = cs[0];
                            h_nxt[c] = h_nxt[c] + 1;
                            // carry out of column 38 is arithmetically always 0
                            if (c < 38) begin
                                nxt[6'(c + 1)][5'(h_nxt[c + 1])] = cs[1];
                                h_nxt[c + 1] = h_nxt[c + 1] + 1;
                            end
                            r = r + 3;
                        end
                    end
                    if (n - r == 2) begin
                        cs = ha(cur[6'(c)][5'(r)], cur[6'(c)][5'(r + 1)]);
                        nxt[6'(c)][5'(h_nxt[c])] = cs[0];
                        h_nxt[c] = h_nxt[c] + 1;
                        if (c < 38) begin
                            nxt[6'(c + 1)][5'(h_nxt[c + 1])] = cs[1];
                            h_nxt[c + 1] = h_nxt[c + 1] + 1;
                        end
                    end else if (n - r == 1) begin
                        nxt[6'(c)][5'(h_nxt[c])] = cur[6'(c)][5'(r)];
                        h_nxt[c] = h_nxt[c] + 1;
                    end
                end
            end

            cur = nxt;
            for (int c = 0; c < 39; c++)
                h_cur[c] = h_nxt[c];
        end

        // final carry-propagate: ripple over the two remaining rows
        carry = 1'b0;
        for (int c = 0; c < 39; c++) begin
            cs             = fa(cur[6'(c)][0], cur[6'(c)][1], carry);
            sum_c[6'(c)]   = cs[0];
            carry          = cs[1];
        end
    end

    logic [38:0] res_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            res_q <= '0;
        else
            res_q <= sum_c;
    end

    assign dst0  = res_q[0];
    assign dst1  = res_q[1];
    assign dst2  = res_q[2];
    assign dst3  = res_q[3];
    assign dst4  = res_q[4];
    assign dst5  = res_q[5];
    assign dst6  = res_q[6];
    assign dst7  = res_q[7];
    assign dst8  = res_q[8];
    assign dst9  = res_q[9];
    assign dst10 = res_q[10];
    assign dst11 = res_q[11];
    assign dst12 = res_q[12];
    assign dst13 = res_q[13];
    assign dst14 = res_q[14];
    assign dst15 = res_q[15];
    assign dst16 = res_q[16];
    assign dst17 = res_q[17];
    assign dst18 = res_q[18];
    assign dst19 = res_q[19];
    assign dst20 = res_q[20];
    assign dst21 = res_q[21];
    assign dst22 = res_q[22];
    assign dst23 = res_q[23];
    assign dst24 = res_q[24];
    assign dst25 = res_q[25];
    assign dst26 = res_q[26];
    assign dst27 = res_q[27];
    assign dst28 = res_q[28];
    assign dst29 = res_q[29];
    assign dst30 = res_q[30];
    assign dst31 = res_q[31];
    assign dst32 = res_q[32];
    assign dst33 = res_q[33];
    assign dst34 = res_q[34];
    assign dst35 = res_q[35];
    assign dst36 = res_q[36];
    assign dst37 = res_q[37];
    assign dst38 = res_q[38];

endmodule

// File: tb/tb_mul19_compressor.sv
module tb_mul19_compressor;

    logic        clk;
    logic        rst_n;
    logic [18:0] col [37];
    wire  [38:0] dst;

    int          n_vec;
    int          n_bad;
    logic [38:0] exp_q [$];

    localparam logic [38:0] ALL_ONES_R = 39'h3F_FFF0_0001;

    mul19_compressor dut (
        .clk   (clk),
        .rst_n (rst_n),
        .src0  (col[0][0:0]),   .src1  (col[1][1:0]),   .src2  (col[2][2:0]),
        .src3  (col[3][3:0]),   .src4  (col[4][4:0]),   .src5  (col[5][5:0]),
        .src6  (col[6][6:0]),   .src7  (col[7][7:0]),   .src8  (col[8][8:0]),
        .src9  (col[9][9:0]),   .src10 (col[10][10:0]), .src11 (col[11][11:0]),
        .src12 (col[12][12:0]), .src13 (col[13][13:0]), .src14 (col[14][14:0]),
        .src15 (col[15][15:0]), .src16 (col[16][16:0]), .src17 (col[17][17:0]),
        .src18 (col[18][18:0]), .src19 (col[19][17:0]), .src20 (col[20][16:0]),
        .src21 (col[21][15:0]), .src22 (col[22][14:0]), .src23 (col[23][13:0]),
        .src24 (col[24][12:0]), .src25 (col[25][11:0]), .src26 (col[26][10:0]),
        .src27 (col[27][9:0]),  .src28 (col[28][8:0]),  .src29 (col[29][7:0]),
        .src30 (col[30][6:0]),  .src31 (col[31][5:0]),  .src32 (col[32][4:0]),
        .src33 (col[33][3:0]),  .src34 (col[34][2:0]),  .src35 (col[35][1:0]),
        .src36 (col[36][0:0]),
        .dst0  (dst[0]),  .dst1  (dst[1]),  .dst2  (dst[2]),  .dst3  (dst[3]),
        .dst4  (dst[4]),  .dst5  (dst[5]),  .dst6  (dst[6]),  .dst7  (dst[7]),
        .dst8  (dst[8]),  .dst9  (dst[9]),  .dst10 (dst[10]), .dst11 (dst[11]),
        .dst12 (dst[12]), .dst13 (dst[13]), .dst14 (dst[14]), .dst15 (dst[15]),
        .dst16 (dst[16]), .dst17 (dst[17]), .dst18 (dst[18]), .dst19 (dst[19]),
        .dst20 (dst[20]), .dst21 (dst[21]), .dst22 (dst[22]), .dst23 (dst[23]),
        .dst24 (dst[24]), .dst25 (dst[25]), .dst26 (dst[26]), .dst27 (dst[27]),
        .dst28 (dst[28]), .dst29 (dst[29]), .dst30 (dst[30]), .dst31 (dst[31]),
        .dst32 (dst[32]), .dst33 (dst[33]), .dst34 (dst[34]), .dst35 (dst[35]),
        .dst36 (dst[36]), .dst37 (dst[37]), .dst38 (dst[38])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int hgt(input int i);
        return (i < 19) ? i + 1 : 37 - i;
    endfunction

    function automatic logic [18:0] hmask(input int i);
        logic [18:0] m;
        m = '0;
        for (int k = 0; k < hgt(i); k++) m[k] = 1'b1;
        return m;
    endfunction

    // popcount-and-shift reference over the currently driven columns
    function automatic logic [38:0] model_sum();
        logic [38:0] acc;
        acc = '0;
        for (int i = 0; i < 37; i++)
            for (int k = 0; k < hgt(i); k++)
                if (col[i][k]) acc = acc + (39'd1 << i);
        return acc;
    endfunction

    task automatic clear_cols();
        for (int i = 0; i < 37; i++) col[i] = '0;
    endtask

    task automatic set_all_ones();
        for (int i = 0; i < 37; i++) col[i] = hmask(i);
    endtask

    task automatic set_product(input logic [18:0] a, input logic [18:0] b);
        int lo;
        for (int i = 0; i < 37; i++) begin
            col[i] = '0;
            lo = (i > 18) ? i - 18 : 0;
            for (int k = lo; k <= i && k <= 18; k++)
                col[i][k - lo] = a[k] & b[i - k];
        end
    endtask

    // queue the expectation for the current inputs, then let one edge sample them
    task automatic push_and_clock(input logic [38:0] e);
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [38:0] e;
        rst_n = 1'b0;
        set_all_ones();
        #3;
        n_vec++;
        if (dst !== 39'd0) begin
            n_bad++;
            $display("FAIL reset_initial got=%h exp=%h", dst, 39'd0);
        end
        @(posedge clk);
        #1;
        n_vec++;
        if (dst !== 39'd0) begin
            n_bad++;
            $display("FAIL reset_held_over_edge got=%h exp=%h", dst, 39'd0);
        end
        clear_cols();
        rst_n = 1'b1;
        push_and_clock(39'd0);
        e = exp_q.pop_front();
        n_vec++;
        if (dst !== e) begin
            n_bad++;
            $display("FAIL all_zero got=%h exp=%h", dst, e);
        end
    endtask

    task automatic test_directed();
        logic [38:0] e;
        set_all_ones();
        push_and_clock(ALL_ONES_R);
        e = exp_q.pop_front();
        n_vec++;
        if (dst !== e || dst[38] !== 1'b0) begin
            n_bad++;
            $display("FAIL all_ones got=%h exp=%h", dst, e);
        end

        clear_cols();
        col[36][0] = 1'b1;
        push_and_clock(39'd1 << 36);
        e = exp_q.pop_front();
        n_vec++;
        if (dst !== e) begin
            n_bad++;
            $display("FAIL single_src36 got=%h exp=%h", dst, e);
        end

        clear_cols();
        col[0][0] = 1'b1;
        push_and_clock(39'd1);
        e = exp_q.pop_front();
        n_vec++;
        if (dst !== e) begin
            n_bad++;
            $display("FAIL single_src0 got=%h exp=%h", dst, e);
        end

        clear_cols();
        col[18] = 19'h7FFFF;
        push_and_clock(39'h4C_0000);
        e = exp_q.pop_front();
        n_vec++;
        if (dst !== e) begin
            n_bad++;
            $display("FAIL col18_full got=%h exp=%h", dst, e);
        end

        set_product(19'h7FFFF, 19'h7FFFF);
        push_and_clock(ALL_ONES_R);
        e = exp_q.pop_front();
        n_vec++;
        if (dst !== e) begin
            n_bad++;
            $display("FAIL product_max got=%h exp=%h", dst, e);
        end
    endtask

    task automatic test_back_to_back_mult();
        logic [18:0] a, b;
        logic [38:0] e;
        for (int t = 0; t < 10000; t++) begin
            a = 19'($urandom);
            b = 19'($urandom);
            if (t % 97 == 0) a = 19'h7FFFF;
            set_product(a, b);
            push_and_clock(39'(38'(a) * 38'(b)));
            e = exp_q.pop_front();
            n_vec++;
            if (dst !== e) begin
                n_bad++;
                $display("FAIL mult a=%h b=%h got=%h exp=%h", a, b, dst, e);
            end
        end
    endtask

    task automatic test_random_cols();
        logic [38:0] e;
        for (int t = 0; t < 2000; t++) begin
            for (int i = 0; i < 37; i++) begin
                col[i] = 19'($urandom) & hmask(i);
                if (t % 5 == 0 && (i % 3 == 0)) col[i] = hmask(i);
            end
            push_and_clock(model_sum());
            e = exp_q.pop_front();
            n_vec++;
            if (dst !== e) begin
                n_bad++;
                $display("FAIL random_cols t=%0d got=%h exp=%h", t, dst, e);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [38:0] e;
        set_all_ones();
        push_and_clock(ALL_ONES_R);
        e = exp_q.pop_front();
        n_vec++;
        if (dst !== e) begin
            n_bad++;
            $display("FAIL mid_pre_reset got=%h exp=%h", dst, e);
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_vec++;
        if (dst !== 39'd0) begin
            n_bad++;
            $display("FAIL mid_async_clear got=%h exp=%h", dst, 39'd0);
        end
        @(posedge clk);
        #1;
        n_vec++;
        if (dst !== 39'd0) begin
            n_bad++;
            $display("FAIL mid_reset_hold got=%h exp=%h", dst, 39'd0);
        end
        clear_cols();
        col[36][0] = 1'b1;
        col[5][3]  = 1'b1;
        #2;
        rst_n = 1'b1;
        push_and_clock((39'd1 << 36) + (39'd1 << 5));
        e = exp_q.pop_front();
        n_vec++;
        if (dst !== e) begin
            n_bad++;
            $display("FAIL mid_after_release got=%h exp=%h", dst, e);
        end
    endtask

    initial begin
        n_vec = 0;
        n_bad = 0;
        rst_n = 1'b0;
        clear_cols();
        test_reset();
        test_directed();
        test_back_to_back_mult();
        test_random_cols();
        test_reset_mid();
        n_vec++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_drain got=%0d exp=%0d", exp_q.size(), 0);
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
